present_cipher_core: RTL and testbench

//  Iterative PRESENT block-cipher engine. Executes one full round per clock (AddRoundKey, sBoxLayer, pLayer)

---
 rtl/present_cipher_core.sv | 187 ++++++++++++++++++
 tb/tb_present_cipher_core.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_cipher_core.sv
// Iterative PRESENT block cipher: one round per clock, on-the-fly key schedule,
// 80/128-bit keys, optional decryption via a forward key-preparation pass.
module present_cipher_core #(
    parameter int unsigned KEY_WIDTH = 80,
    parameter int unsigned ROUNDS    = 31,
    parameter bit          DEC_EN    = 1'b1
) (
    input  logic                 Clk_ik,
    input  logic                 Reset_irn,
    input  logic                 Start_i,
    input  logic                 Decrypt_i,
    input  logic [63:0]          Data_ib,
    input  logic [KEY_WIDTH-1:0] Key_ib,
    output logic                 Ready_o,
    output logic                 Done_o,
    output logic [63:0]          Data_ob
);

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : gBadKeyWidth
        $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : gBadRounds
        $error("present_cipher_core: ROUNDS must be in 1..31");
    end

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sboxInv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sLayer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] sLayerInv(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sboxInv(x[4*i +: 4]);
        return y;
    endfunction

    // Bit j of nibble i moves to position 16*j+i.
    function automatic logic [63:0] pLayer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++) y[16*j+i] = x[4*i+j];
        return y;
    endfunction

    function automatic logic [63:0] pLayerInv(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++) y[4*i+j] = x[16*j+i];
        return y;
    endfunction

    typedef enum logic [2:0] {StIdle, StEnc, StKprep, StDec, StDone} fsmState_t;

    fsmState_t            stateQ, stateD;
    logic [63:0]          dataQ, outQ;
    logic [KEY_WIDTH-1:0] keyQ, keyRot, keyFwd, keyXor, keyBwd;
    logic [4:0]           rcQ;
    logic                 doneQ;
    logic                 decSel, lastRound, roundsDone;
    logic [63:0]          rkCur, rkFwd, rkBwd;

    assign decSel     = DEC_EN && Decrypt_i;
    assign lastRound  = (rcQ == 5'(ROUNDS));
    assign roundsDone = (rcQ == 5'd0);

    // Forward schedule U(key, rc) and its inverse Uinv(key, rc).
    assign keyRot = {keyQ[KEY_WIDTH-62:0], keyQ[KEY_WIDTH-1:KEY_WIDTH-61]};
    if (KEY_WIDTH == 128) begin : gKey128
        always_comb begin
            keyFwd            = keyRot;
            keyFwd[127:124]   = sbox(keyRot[127:124]);
            keyFwd[123:120]   = sbox(keyRot[123:120]);
            keyFwd[66:62]     = keyRot[66:62] ^ rcQ;
            keyXor            = keyQ;
            keyXor[127:124]   = sboxInv(keyQ[127:124]);
            keyXor[123:120]   = sboxInv(keyQ[123:120]);
            keyXor[66:62]     = keyQ[66:62] ^ rcQ;
        end
    end else begin : gKey80
        always_comb begin
            keyFwd            = keyRot;
            keyFwd[79:76]     = sbox(keyRot[79:76]);
            keyFwd[19:15]     = keyRot[19:15] ^ rcQ;
            keyXor            = keyQ;
            keyXor[79:76]     = sboxInv(keyQ[79:76]);
            keyXor[19:15]     = keyQ[19:15] ^ rcQ;
        end
    end
    assign keyBwd = {keyXor[60:0], keyXor[KEY_WIDTH-1:61]};

    assign rkCur = keyQ[KEY_WIDTH-1 -: 64];
    assign rkFwd = keyFwd[KEY_WIDTH-1 -: 64];
    assign rkBwd = keyBwd[KEY_WIDTH-1 -: 64];

    always_ff @(posedge Clk_ik or negedge Reset_irn) begin
        if (!Reset_irn) stateQ <= StIdle;
        else            stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle, StDone: if (Start_i) stateD = decSel ? StKprep : StEnc;
            StEnc, StDec:   if (roundsDone) stateD = StDone;
            StKprep:        if (lastRound) stateD = StDec;
            default:        stateD = StIdle;
        endcase
    end

    always_comb begin
        Ready_o = (stateQ == StIdle) || (stateQ == StDone);
        Done_o  = doneQ;
        Data_ob = outQ;
    end

    // rc==0 inside ENC/DEC marks the extra output cycle after the last round.
    always_ff @(posedge Clk_ik or negedge Reset_irn) begin
        if (!Reset_irn) begin
            dataQ <= '0;
            keyQ  <= '0;
            rcQ   <= '0;
            outQ  <= '0;
            doneQ <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            unique case (stateQ)
                StIdle, StDone: begin
                    if (Start_i) begin
                        dataQ <= Data_ib;
                        keyQ  <= Key_ib;
                        rcQ   <= 5'd1;
                    end
                end
                StEnc: begin
                    if (roundsDone) begin
                        outQ  <= dataQ ^ rkCur;
                        doneQ <= 1'b1;
                    end else begin
                        dataQ <= pLayer(sLayer(dataQ ^ rkCur));
                        keyQ  <= keyFwd;
                        rcQ   <= lastRound ? 5'd0 : rcQ + 5'd1;
                    end
                end
                StKprep: begin
                    keyQ <= keyFwd;
                    if (lastRound) dataQ <= dataQ ^ rkFwd;
                    else           rcQ   <= rcQ + 5'd1;
                end
                StDec: begin
                    if (roundsDone) begin
                        outQ  <= dataQ;
                        doneQ <= 1'b1;
                    end else begin
                        dataQ <= sLayerInv(pLayerInv(dataQ)) ^ rkBwd;
                        keyQ  <= keyBwd;
                        rcQ   <= rcQ - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_cipher_core.sv
// Bench for present_cipher_core: known-answer table, random ops against a
// bit-level PRESENT model, plus busy/back-to-back/reset sequences.
module tb_present_cipher_core;

    logic         clk = 1'b0;
    logic         rstN, start, startLite, decrypt;
    logic [63:0]  dataIn;
    logic [127:0] key128;
    logic         ready80, done80, ready128, done128, readyL, doneL;
    logic [63:0]  out80, out128, outL;

    always #5 clk = ~clk;

    present_cipher_core #(.KEY_WIDTH(80), .ROUNDS(31), .DEC_EN(1'b1)) dut80 (
        .Clk_ik(clk), .Reset_irn(rstN), .Start_i(start), .Decrypt_i(decrypt),
        .Data_ib(dataIn), .Key_ib(key128[79:0]), .Ready_o(ready80), .Done_o(done80),
        .Data_ob(out80));

    present_cipher_core #(.KEY_WIDTH(128), .ROUNDS(31), .DEC_EN(1'b1)) dut128 (
        .Clk_ik(clk), .Reset_irn(rstN), .Start_i(start), .Decrypt_i(decrypt),
        .Data_ib(dataIn), .Key_ib(key128), .Ready_o(ready128), .Done_o(done128),
        .Data_ob(out128));

    present_cipher_core #(.KEY_WIDTH(80), .ROUNDS(5), .DEC_EN(1'b0)) dutLite (
        .Clk_ik(clk), .Reset_irn(rstN), .Start_i(startLite), .Decrypt_i(decrypt),
        .Data_ib(dataIn), .Key_ib(key128[79:0]), .Ready_o(readyL), .Done_o(doneL),
        .Data_ob(outL));

    int checks = 0;
    int errors = 0;
    int q80[$], q128[$], qL[$];
    logic [63:0] v80[$], v128[$], vL[$];

    // ---------------- reference model ----------------
    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] t;
        int xi;
        t  = 64'hC56B90AD3EF84712;
        xi = int'(x);
        return t[60 - 4*xi +: 4];
    endfunction

    function automatic logic [3:0] sbInv(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++) if (sb(4'(v)) == x) r = 4'(v);
        return r;
    endfunction

    function automatic int pos(input int b);
        return (b == 63) ? 63 : (16 * b) % 63;
    endfunction

    function automatic logic [63:0] model(input logic dec, input logic [63:0] din,
                                          input logic [127:0] key, input int kw,
                                          input int rounds);
        logic [63:0]  rks [0:32];
        logic [127:0] k, nk;
        logic [63:0]  s, ns;
        k = key;
        for (int r = 1; r <= rounds + 1; r++) begin
            rks[r] = k[kw-1 -: 64];
            nk = '0;
            for (int b = 0; b < kw; b++) nk[(b + 61) % kw] = k[b];
            k = nk;
            k[kw-1 -: 4] = sb(k[kw-1 -: 4]);
            if (kw == 128) begin
                k[kw-5 -: 4] = sb(k[kw-5 -: 4]);
                k[66:62] = k[66:62] ^ 5'(r);
            end else begin
                k[19:15] = k[19:15] ^ 5'(r);
            end
        end
        if (!dec) begin
            s = din;
            for (int r = 1; r <= rounds; r++) begin
                s = s ^ rks[r];
                for (int i = 0; i < 16; i++) s[4*i +: 4] = sb(s[4*i +: 4]);
                for (int b = 0; b < 64; b++) ns[pos(b)] = s[b];
                s = ns;
            end
            return s ^ rks[rounds + 1];
        end
        s = din ^ rks[rounds + 1];
        for (int r = rounds; r >= 1; r--) begin
            for (int b = 0; b < 64; b++) ns[b] = s[pos(b)];
            s = ns;
            for (int i = 0; i < 16; i++) s[4*i +: 4] = sbInv(s[4*i +: 4]);
            s = s ^ rks[r];
        end
        return s;
    endfunction

    // ---------------- helpers ----------------
    task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic launch(input logic dec, input logic [63:0] d, input logic [127:0] k,
                          input logic lite);
        decrypt = dec; dataIn = d; key128 = k; start = 1'b1; startLite = lite;
        @(negedge clk);
        start = 1'b0; startLite = 1'b0;
    endtask

    // Watches win cycles after the accept edge; optionally pulses Start at cycle pulseAt.
    task automatic observe(input int win, input int pulseAt, input logic pDec,
                           input logic [63:0] pData, input logic [127:0] pKey);
        q80.delete(); q128.delete(); qL.delete();
        v80.delete(); v128.delete(); vL.delete();
        for (int n = 0; n < win; n++) begin
            if (done80)  begin q80.push_back(n);  v80.push_back(out80);  end
            if (done128) begin q128.push_back(n); v128.push_back(out128); end
            if (doneL)   begin qL.push_back(n);   vL.push_back(outL);    end
            if (n == pulseAt) begin
                start = 1'b1; decrypt = pDec; dataIn = pData; key128 = pKey;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic checkResult(input int which, input string tag, input int expLat,
                               input logic [63:0] expVal);
        int cnt, lat;
        logic [63:0] val, now;
        cnt = 0; lat = -1; val = 'x; now = 'x;
        case (which)
            0: begin cnt = q80.size();  if (cnt > 0) begin lat = q80[0];  val = v80[0];  end
                     now = out80; end
            1: begin cnt = q128.size(); if (cnt > 0) begin lat = q128[0]; val = v128[0]; end
                     now = out128; end
            default: begin cnt = qL.size(); if (cnt > 0) begin lat = qL[0]; val = vL[0]; end
                     now = outL; end
        endcase
        checkVal({tag, " pulses"}, 64'(cnt), 64'd1);
        checkVal({tag, " latency"}, 64'(lat), 64'(expLat));
        checkVal({tag, " result"}, val, expVal);
        checkVal({tag, " held"}, now, expVal);
    endtask

    typedef struct packed {
        logic         dec;
        logic [63:0]  din;
        logic [127:0] key;
        logic         kw128;
        logic [63:0]  exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic         rdec;
        logic [63:0]  rdata;
        logic [127:0] rkey;
        int           lat;

        vecs[0] = '{dec: 1'b0, din: 64'h0, key: 128'h0, kw128: 1'b0, exp: 64'h5579C1387B228445};
        vecs[1] = '{dec: 1'b0, din: 64'h0, key: 128'hFFFFFFFFFFFFFFFFFFFF, kw128: 1'b0,
                    exp: 64'hE72C46C0F5945049};
        vecs[2] = '{dec: 1'b0, din: 64'hFFFFFFFFFFFFFFFF, key: 128'h0, kw128: 1'b0,
                    exp: 64'hA112FFC72F68417B};
        vecs[3] = '{dec: 1'b1, din: 64'h3333DCD3213210D2, key: 128'hFFFFFFFFFFFFFFFFFFFF,
                    kw128: 1'b0, exp: 64'hFFFFFFFFFFFFFFFF};
        vecs[4] = '{dec: 1'b0, din: 64'h0, key: 128'h0, kw128: 1'b1, exp: 64'h96DB702A2E6900AF};
        vecs[5] = '{dec: 1'b1, din: 64'h96DB702A2E6900AF, key: 128'h0, kw128: 1'b1,
                    exp: 64'h0};

        rstN = 1'b0; start = 1'b0; startLite = 1'b0; decrypt = 1'b0;
        dataIn = '0; key128 = '0;
        repeat (3) @(negedge clk);
        checkVal("reset ready80", 64'(ready80), 64'd1);
        checkVal("reset done80", 64'(done80), 64'd0);
        checkVal("reset out80", out80, 64'd0);
        checkVal("reset ready128", 64'(ready128), 64'd1);
        checkVal("reset done128", 64'(done128), 64'd0);
        checkVal("reset out128", out128, 64'd0);
        checkVal("reset readyLite", 64'(readyL), 64'd1);
        checkVal("reset outLite", outL, 64'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Known-answer vectors; the DUT of the other key size is checked against the model.
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].dec, vecs[i].din, vecs[i].key, 1'b1);
            observe(70, -1, 1'b0, 64'h0, 128'h0);
            lat = vecs[i].dec ? 63 : 32;
            if (vecs[i].kw128) begin
                checkResult(1, $sformatf("kat%0d k128", i), lat, vecs[i].exp);
                checkResult(0, $sformatf("kat%0d k80", i), lat,
                            model(vecs[i].dec, vecs[i].din, {48'h0, vecs[i].key[79:0]}, 80, 31));
            end else begin
                checkResult(0, $sformatf("kat%0d k80", i), lat, vecs[i].exp);
                checkResult(1, $sformatf("kat%0d k128", i), lat,
                            model(vecs[i].dec, vecs[i].din, vecs[i].key, 128, 31));
            end
            checkResult(2, $sformatf("kat%0d lite", i), 6,
                        model(1'b0, vecs[i].din, {48'h0, vecs[i].key[79:0]}, 80, 5));
        end

        // Random operations against the model.
        for (int i = 0; i < 8; i++) begin
            rdec  = 1'($urandom_range(0, 1));
            rdata = {$urandom, $urandom};
            rkey  = {$urandom, $urandom, $urandom, $urandom};
            launch(rdec, rdata, rkey, 1'b1);
            observe(70, -1, 1'b0, 64'h0, 128'h0);
            lat = rdec ? 63 : 32;
            checkResult(0, $sformatf("rnd%0d k80", i), lat,
                        model(rdec, rdata, {48'h0, rkey[79:0]}, 80, 31));
            checkResult(1, $sformatf("rnd%0d k128", i), lat, model(rdec, rdata, rkey, 128, 31));
            checkResult(2, $sformatf("rnd%0d lite", i), 6,
                        model(1'b0, rdata, {48'h0, rkey[79:0]}, 80, 5));
        end

        // Start while busy is ignored.
        launch(1'b0, 64'h0, 128'h0, 1'b0);
        checkVal("busy ready80", 64'(ready80), 64'd0);
        observe(70, 10, 1'b1, 64'hFFFFFFFFFFFFFFFF, {128{1'b1}});
        checkResult(0, "busy k80", 32, 64'h5579C1387B228445);
        checkResult(1, "busy k128", 32, 64'h96DB702A2E6900AF);

        // Start in the Done_o cycle: encrypt then decrypt back-to-back.
        launch(1'b0, 64'h0, 128'h0, 1'b0);
        observe(100, 32, 1'b1, 64'h3333DCD3213210D2, 128'hFFFFFFFFFFFFFFFFFFFF);
        checkVal("b2b pulses80", 64'(q80.size()), 64'd2);
        checkVal("b2b pulses128", 64'(q128.size()), 64'd2);
        if (q80.size() == 2) begin
            checkVal("b2b lat80a", 64'(q80[0]), 64'd32);
            checkVal("b2b out80a", v80[0], 64'h5579C1387B228445);
            checkVal("b2b lat80b", 64'(q80[1]), 64'd96);
            checkVal("b2b out80b", v80[1], 64'hFFFFFFFFFFFFFFFF);
        end
        if (q128.size() == 2) begin
            checkVal("b2b lat128b", 64'(q128[1]), 64'd96);
            checkVal("b2b out128b", v128[1],
                     model(1'b1, 64'h3333DCD3213210D2, 128'hFFFFFFFFFFFFFFFFFFFF, 128, 31));
        end

        // Reset mid-operation aborts immediately; restart gives the normal result.
        launch(1'b0, 64'h0, 128'h0, 1'b0);
        repeat (10) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkVal("abort ready80", 64'(ready80), 64'd1);
        checkVal("abort done80", 64'(done80), 64'd0);
        checkVal("abort out80", out80, 64'd0);
        checkVal("abort out128", out128, 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        launch(1'b0, 64'h0, 128'h0, 1'b0);
        observe(70, -1, 1'b0, 64'h0, 128'h0);
        checkResult(0, "restart k80", 32, 64'h5579C1387B228445);
        checkResult(1, "restart k128", 32, 64'h96DB702A2E6900AF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
